// File: rtl/receptor_pkg.sv
// rtl/receptor_pkg.sv - shared types and constants for the serial frame receptor controller
package receptor_pkg;

    localparam int MAX_FRAME_LEN = 16;
    localparam int CNT_W         = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_LATCH  = 3'd2,
        ST_PARITY = 3'd3,
        ST_VALID  = 3'd4
    } state_t;

endpackage

// File: rtl/receptor_parity.sv
// rtl/receptor_parity.sv - even-parity accumulator over the shifted data bits
module receptor_parity (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic bit_in,
    output logic parity
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            parity <= 1'b0;
        end else if (enable) begin
            parity <= parity ^ bit_in;
        end
    end

endmodule

// File: rtl/receptor_ctrl.sv
// rtl/receptor_ctrl.sv - shift-receiver sequencer with handshake, overrun flag; parity via RECEPTOR_PARITY_CHECK_EN
module receptor_ctrl
    import receptor_pkg::*;
#(
    parameter int FRAME_LEN = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             serial_in,
    output logic             shift_en,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

    state_t state;
    logic   shift_start;

    // A new frame begins either from IDLE or straight out of a completed VALID handshake.
    assign shift_start = start && ((state == ST_IDLE) ||
                                   ((state == ST_VALID) && frame_ready));

`ifdef RECEPTOR_PARITY_CHECK_EN
    logic acc;

    receptor_parity u_parity (
        .clk    (CLK),
        .rst    (RST),
        .clear  (shift_start),
        .enable (state == ST_SHIFT),
        .bit_in (serial_in),
        .parity (acc)
    );

    always_ff @(posedge CLK) begin
        if (RST || shift_start) begin
            parity_err <= 1'b0;
        end else if (state == ST_PARITY) begin
            parity_err <= acc ^ serial_in;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            shift_en    <= 1'b0;
            frame_valid <= 1'b0;
            bit_cnt     <= '0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_SHIFT;
                        shift_en <= 1'b1;
                        busy     <= 1'b1;
                        bit_cnt  <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (bit_cnt == LAST_BIT) begin
                        shift_en <= 1'b0;
                        bit_cnt  <= '0;
`ifdef RECEPTOR_PARITY_CHECK_EN
                        state    <= ST_PARITY;
`else
                        state    <= ST_LATCH;
`endif
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
`ifdef RECEPTOR_PARITY_CHECK_EN
                ST_PARITY: begin
                    if (start) overrun <= 1'b1;
                    state <= ST_LATCH;
                end
`endif
                ST_LATCH: begin
                    if (start) overrun <= 1'b1;
                    state       <= ST_VALID;
                    frame_valid <= 1'b1;
                end
                ST_VALID: begin
                    if (frame_ready) begin
                        frame_valid <= 1'b0;
                        if (start) begin
                            state    <= ST_SHIFT;
                            shift_en <= 1'b1;
                            bit_cnt  <= '0;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (start) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    shift_en    <= 1'b0;
                    frame_valid <= 1'b0;
                    bit_cnt     <= '0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_receptor_ctrl.sv
// tb/tb_receptor_ctrl.sv - directed self-checking bench for receptor_ctrl
module tb_receptor_ctrl;

`ifdef RECEPTOR_PARITY_CHECK_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL  = 16;
    localparam int FL8 = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start = 1'b0, serial_in = 1'b0, frame_ready = 1'b0;
    logic       shift_en, frame_valid, busy, overrun, parity_err;
    logic [4:0] bit_cnt;

    logic       start8 = 1'b0, serial8 = 1'b0, ready8 = 1'b0;
    logic       shift_en8, frame_valid8, busy8, overrun8, parity_err8;
    logic [4:0] bit_cnt8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    receptor_ctrl #(.FRAME_LEN(FL)) u_dut (
        .CLK(CLK), .RST(RST), .start(start), .serial_in(serial_in),
        .shift_en(shift_en), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .bit_cnt(bit_cnt), .busy(busy), .overrun(overrun), .parity_err(parity_err)
    );

    receptor_ctrl #(.FRAME_LEN(FL8)) u_dut8 (
        .CLK(CLK), .RST(RST), .start(start8), .serial_in(serial8),
        .shift_en(shift_en8), .frame_valid(frame_valid8), .frame_ready(ready8),
        .bit_cnt(bit_cnt8), .busy(busy8), .overrun(overrun8), .parity_err(parity_err8)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_shift_en"}, 32'(shift_en), 0);
        check({tag, "_frame_valid"}, 32'(frame_valid), 0);
        check({tag, "_bit_cnt"}, 32'(bit_cnt), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_overrun"}, 32'(overrun), 0);
        check({tag, "_parity_err"}, 32'(parity_err), 0);
    endtask

    task automatic parity_frame(input logic [7:0] data, input logic pbit);
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < FL8; i++) begin
            serial8 = data[7-i];
            tick();
        end
        serial8 = pbit;
        repeat (PAR) tick();
        serial8 = 1'b0;
        check("p8_pre_valid", 32'(frame_valid8), 0);
        tick();
        check("p8_valid", 32'(frame_valid8), 1);
        check("p8_parity_err", 32'(parity_err8), (PAR == 1) ? 32'(pbit) : 0);
        ready8 = 1'b1;
        tick();
        ready8 = 1'b0;
        check("p8_idle", 32'(busy8), 0);
    endtask

    initial begin
        logic seen_bad;

        // Reset state
        repeat (2) tick();
        check_reset("rst");
        RST = 1'b0;

        // Basic frame: start at edge k, SHIFT cycles k+1..k+FL
        start = 1'b1;
        tick();
        start = 1'b0;
        check("shift0_en", 32'(shift_en), 1);
        check("shift0_cnt", 32'(bit_cnt), 0);
        check("shift0_busy", 32'(busy), 1);
        seen_bad = 1'b0;
        for (int i = 1; i < FL; i++) begin
            if (i == 5) start = 1'b1;
            tick();
            start = 1'b0;
            if (shift_en !== 1'b1 || bit_cnt !== 5'(i) || frame_valid !== 1'b0) seen_bad = 1'b1;
        end
        check("shift_run", 32'(seen_bad), 0);
        check("shift_start_ignored", 32'(overrun), 0);
        tick();
        check("latch_shift_en", 32'(shift_en), 0);
        check("latch_cnt", 32'(bit_cnt), 0);
        check("latch_valid", 32'(frame_valid), 0);
        repeat (PAR) tick();
        tick();
        check("valid_first", 32'(frame_valid), 1);
        check("valid_shift_en", 32'(shift_en), 0);

        // Hold VALID for 5 cycles without frame_ready
        seen_bad = 1'b0;
        repeat (5) begin
            tick();
            if (frame_valid !== 1'b1) seen_bad = 1'b1;
        end
        check("valid_hold", 32'(seen_bad), 0);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        check("release_valid", 32'(frame_valid), 0);
        check("release_busy", 32'(busy), 0);

        // Back-to-back: start together with frame_ready in VALID
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (FL + PAR + 1) tick();
        check("b2b_valid", 32'(frame_valid), 1);
        start = 1'b1;
        frame_ready = 1'b1;
        tick();
        start = 1'b0;
        frame_ready = 1'b0;
        check("b2b_shift_en", 32'(shift_en), 1);
        check("b2b_cnt", 32'(bit_cnt), 0);
        check("b2b_overrun", 32'(overrun), 0);
        check("b2b_valid_drop", 32'(frame_valid), 0);
        repeat (FL + PAR + 1) tick();
        check("b2b_valid2", 32'(frame_valid), 1);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;

        // Start in LATCH is lost and sets the sticky overrun
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (FL + PAR) tick();
        check("ovr_in_latch", 32'(shift_en), 0);
        check("ovr_in_latch_busy", 32'(busy), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ovr_set", 32'(overrun), 1);
        check("ovr_valid", 32'(frame_valid), 1);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        check("ovr_idle", 32'(busy), 0);
        repeat (3) tick();
        check("ovr_no_frame", 32'(shift_en), 0);
        check("ovr_sticky", 32'(overrun), 1);

        // Reset mid-frame at bit_cnt 7, start held during the reset edge
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        check("mid_cnt7", 32'(bit_cnt), 7);
        RST = 1'b1;
        start = 1'b1;
        tick();
        RST = 1'b0;
        start = 1'b0;
        check_reset("mid_rst");
        seen_bad = 1'b0;
        repeat (FL + 8) begin
            tick();
            if (frame_valid !== 1'b0 || busy !== 1'b0) seen_bad = 1'b1;
        end
        check("mid_no_valid", 32'(seen_bad), 0);

        // FRAME_LEN=8 instance: 0xA5 with parity bit 1 then 0
        parity_frame(8'hA5, 1'b1);
        parity_frame(8'hA5, 1'b0);
        check("p8_overrun", 32'(overrun8), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
